// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
//   Phase scheduler for a highway/street intersection. Synchronises the
//   street car sensor and the pedestrian button, latches requests, and steps
//   through highway green -> yellow -> all-red -> street green (or walk)
//   with fixed per-phase timing. Drives six lamps, the walk lamp and a
//   two-digit BCD countdown of the seconds remaining in the current phase.
//
//   Optional feature macro: TLS_PED_PHASE_EN
//     defined   : pedestrian button path, ped request latch and WALK phase built
//     undefined : ped_btn ignored, walk tied low, street green always served
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous, active-high reset
//   car_async        in   street car sensor (asynchronous level)
//   ped_btn          in   pedestrian push button (asynchronous level)
//   red/yellow/green_highway  out  highway lamps
//   red/yellow/green_street   out  street lamps
//   walk             out  pedestrian walk lamp
//   count_tens       out  BCD tens digit of remaining seconds
//   count_ones       out  BCD ones digit of remaining seconds
//   phase            out  current state encoding (debug)
//
// Handshake: none; all inputs are levels, all outputs are Moore decodes.
// ---------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int TICK_DIV   = 1000000,
  parameter int T_HW_GREEN = 10,
  parameter int T_ST_GREEN = 8,
  parameter int T_YELLOW   = 3,
  parameter int T_ALL_RED  = 1,
  parameter int T_WALK     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_async,
  input  logic       ped_btn,
  output logic       red_highway,
  output logic       yellow_highway,
  output logic       green_highway,
  output logic       red_street,
  output logic       yellow_street,
  output logic       green_street,
  output logic       walk,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_HW_GREEN  = 3'd0,
    S_HW_YELLOW = 3'd1,
    S_ALL_RED_A = 3'd2,
    S_ST_GREEN  = 3'd3,
    S_ST_YELLOW = 3'd4,
    S_ALL_RED_B = 3'd5,
    S_WALK      = 3'd6
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_timer;
  logic          r_car_s1, r_car_s2;
  logic          r_car_pend;
  logic          w_tick;
  logic          w_state_chg;
  logic          w_timer_zero;
  logic          w_enter_st;

  // Duration in seconds of the phase being entered.
  function automatic logic [6:0] phase_dur(input state_t s);
    case (s)
      S_HW_GREEN:  return 7'(T_HW_GREEN);
      S_HW_YELLOW: return 7'(T_YELLOW);
      S_ALL_RED_A: return 7'(T_ALL_RED);
      S_ST_GREEN:  return 7'(T_ST_GREEN);
      S_ST_YELLOW: return 7'(T_YELLOW);
      S_ALL_RED_B: return 7'(T_ALL_RED);
      S_WALK:      return 7'(T_WALK);
      default:     return 7'(T_HW_GREEN);
    endcase
  endfunction

  assign w_tick       = (r_presc == PRE_MAX);
  assign w_state_chg  = (w_next_state != r_state);
  assign w_timer_zero = (r_timer == 7'd0);
  assign w_enter_st   = (w_next_state == S_ST_GREEN) && (r_state != S_ST_GREEN);

  // Car sensor synchroniser and request latch (clear on street-green entry wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_car_s1   <= 1'b0;
      r_car_s2   <= 1'b0;
      r_car_pend <= 1'b0;
    end else begin
      r_car_s1 <= car_async;
      r_car_s2 <= r_car_s1;
      if (w_enter_st)    r_car_pend <= 1'b0;
      else if (r_car_s2) r_car_pend <= 1'b1;
    end
  end

`ifdef TLS_PED_PHASE_EN
  logic r_ped_s1, r_ped_s2, r_ped_s3;
  logic r_ped_pend;
  logic w_ped_edge;
  logic w_enter_walk;

  assign w_ped_edge   = r_ped_s2 & ~r_ped_s3;
  assign w_enter_walk = (w_next_state == S_WALK) && (r_state != S_WALK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ped_s1   <= 1'b0;
      r_ped_s2   <= 1'b0;
      r_ped_s3   <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_ped_s1 <= ped_btn;
      r_ped_s2 <= r_ped_s1;
      r_ped_s3 <= r_ped_s2;
      if (w_enter_walk)    r_ped_pend <= 1'b0;
      else if (w_ped_edge) r_ped_pend <= 1'b1;
    end
  end
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_btn;
`endif

  // State register, prescaler and phase timer. Any state change restarts the
  // prescaler and reloads the timer, so a phase of T seconds lasts
  // T*TICK_DIV+1 cycles (the extra cycle is the timer==0 exit cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HW_GREEN;
      r_presc <= '0;
      r_timer <= 7'(T_HW_GREEN);
    end else begin
      r_state <= w_next_state;
      if (w_state_chg) begin
        r_presc <= '0;
        r_timer <= phase_dur(w_next_state);
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick && !w_timer_zero) r_timer <= r_timer - 7'd1;
      end
    end
  end

  // Next state and Moore lamp decode.
  always_comb begin
    w_next_state   = r_state;
    red_highway    = 1'b1;
    yellow_highway = 1'b0;
    green_highway  = 1'b0;
    red_street     = 1'b1;
    yellow_street  = 1'b0;
    green_street   = 1'b0;
    walk           = 1'b0;
    case (r_state)
      S_HW_GREEN: begin
        red_highway   = 1'b0;
        green_highway = 1'b1;
`ifdef TLS_PED_PHASE_EN
        if (w_timer_zero && (r_car_pend || r_ped_pend)) w_next_state = S_HW_YELLOW;
`else
        if (w_timer_zero && r_car_pend) w_next_state = S_HW_YELLOW;
`endif
      end
      S_HW_YELLOW: begin
        red_highway    = 1'b0;
        yellow_highway = 1'b1;
        if (w_timer_zero) w_next_state = S_ALL_RED_A;
      end
      S_ALL_RED_A: begin
`ifdef TLS_PED_PHASE_EN
        // Street has priority when both requests are waiting.
        if (w_timer_zero) w_next_state = r_car_pend ? S_ST_GREEN : S_WALK;
`else
        if (w_timer_zero) w_next_state = S_ST_GREEN;
`endif
      end
      S_ST_GREEN: begin
        red_street   = 1'b0;
        green_street = 1'b1;
        if (w_timer_zero) w_next_state = S_ST_YELLOW;
      end
      S_ST_YELLOW: begin
        red_street    = 1'b0;
        yellow_street = 1'b1;
        if (w_timer_zero) w_next_state = S_ALL_RED_B;
      end
      S_ALL_RED_B: begin
`ifdef TLS_PED_PHASE_EN
        if (w_timer_zero) w_next_state = r_ped_pend ? S_WALK : S_HW_GREEN;
`else
        if (w_timer_zero) w_next_state = S_HW_GREEN;
`endif
      end
`ifdef TLS_PED_PHASE_EN
      S_WALK: begin
        walk = 1'b1;
        if (w_timer_zero) w_next_state = S_HW_GREEN;
      end
`endif
      default: w_next_state = S_HW_GREEN;
    endcase
  end

  assign count_tens = 4'(r_timer / 7'd10);
  assign count_ones = 4'(r_timer % 7'd10);
  assign phase      = r_state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

  localparam int W = 26; // {dur[7:0], phase[2:0], lamps[6:0], bcd[7:0]}

  localparam logic [6:0] L_HG = 7'b0011000;
  localparam logic [6:0] L_HY = 7'b0101000;
  localparam logic [6:0] L_AR = 7'b1001000;
  localparam logic [6:0] L_SG = 7'b1000010;
  localparam logic [6:0] L_SY = 7'b1000100;
  localparam logic [6:0] L_WK = 7'b1001001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       car_async = 1'b0;
  logic       ped_btn = 1'b0;
  logic       red_highway, yellow_highway, green_highway;
  logic       red_street, yellow_street, green_street;
  logic       walk;
  logic [3:0] count_tens, count_ones;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  traffic_phase_sequencer #(
    .TICK_DIV(4), .T_HW_GREEN(3), .T_ST_GREEN(2),
    .T_YELLOW(2), .T_ALL_RED(1), .T_WALK(2)
  ) dut (
    .clk(clk), .reset(reset), .car_async(car_async), .ped_btn(ped_btn),
    .red_highway(red_highway), .yellow_highway(yellow_highway),
    .green_highway(green_highway), .red_street(red_street),
    .yellow_street(yellow_street), .green_street(green_street),
    .walk(walk), .count_tens(count_tens), .count_ones(count_ones),
    .phase(phase)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [6:0] lamps();
    return {red_highway, yellow_highway, green_highway,
            red_street, yellow_street, green_street, walk};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset release lands 2 time units after a posedge; the next negedge is cycle 0.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic exp_push(input int dur, input logic [2:0] ph,
                          input logic [6:0] lm, input logic [7:0] bcd);
    exp_q.push_back({8'(dur), ph, lm, bcd});
  endtask

  task automatic pulse_inputs(input int start, input int len, input logic car, input logic ped);
    repeat (start) @(posedge clk);
    #1;
    car_async = car;
    ped_btn   = ped;
    repeat (len) @(posedge clk);
    #1;
    car_async = 1'b0;
    ped_btn   = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] target, input int max_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      if (phase == target) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_phase: phase %0d not reached in %0d cycles", target, max_cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         mon_cnt  = 0;
  logic [2:0] mon_prev = 3'd0;

  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    // Lamp safety on every sampled cycle.
    total++;
    if ((green_highway & green_street) ||
        !$onehot({red_highway, yellow_highway, green_highway}) ||
        !$onehot({red_street, yellow_street, green_street})) begin
      bad++;
      $display("FAIL lamp_safety: lamps=%b at %0t", lamps(), $time);
    end
    if (reset) begin
      mon_cnt  = 0;
      mon_prev = 3'd0;
    end else if (phase != mon_prev) begin
      act = {8'(mon_cnt), phase, lamps(), count_tens, count_ones};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL phase_change: unexpected entry got=%h at %0t", act, $time);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL phase_change: got=%h expected=%h at %0t", act, e, $time);
        end
      end
      mon_prev = phase;
      mon_cnt  = 1;
    end else begin
      mon_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  int         chk_cyc[5] = '{0, 4, 8, 12, 99};
  logic [7:0] chk_bcd[5] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h00};

  initial begin
    // Test 1: idle, countdown 3,2,1,0 then holds 00 with highway green.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (chk_cyc[k] == c) begin
          chk("idle_count", {8'h0, count_tens, count_ones}, {8'h0, chk_bcd[k]});
          chk("idle_lamps", {9'h0, lamps()}, {9'h0, L_HG});
        end
      end
    end
    chk("idle_queue", 16'(exp_q.size()), 16'd0);

    // Test 2: car request, full street cycle.
    do_reset();
    exp_push(13, 3'd1, L_HY, 8'h02);
    exp_push(9,  3'd2, L_AR, 8'h01);
    exp_push(5,  3'd3, L_SG, 8'h02);
    exp_push(9,  3'd4, L_SY, 8'h02);
    exp_push(9,  3'd5, L_AR, 8'h01);
    exp_push(5,  3'd0, L_HG, 8'h03);
    pulse_inputs(5, 3, 1'b1, 1'b0);
    repeat (70) @(negedge clk);
    chk("car_queue", 16'(exp_q.size()), 16'd0);

    // Test 3: reset during street green drops the pending state.
    do_reset();
    exp_push(13, 3'd1, L_HY, 8'h02);
    exp_push(9,  3'd2, L_AR, 8'h01);
    exp_push(5,  3'd3, L_SG, 8'h02);
    pulse_inputs(5, 3, 1'b1, 1'b0);
    wait_phase(3'd3, 100);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_green_hw", {15'h0, green_highway}, 16'h1);
    chk("rst_green_st", {15'h0, green_street}, 16'h0);
    chk("rst_count", {8'h0, count_tens, count_ones}, 16'h0003);
    chk("rst_car_pend", {15'h0, dut.r_car_pend}, 16'h0);
    chk("rst_phase", {13'h0, phase}, 16'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_queue", 16'(exp_q.size()), 16'd0);

`ifdef TLS_PED_PHASE_EN
    // Test 4: car and ped together: street first, then walk.
    do_reset();
    exp_push(13, 3'd1, L_HY, 8'h02);
    exp_push(9,  3'd2, L_AR, 8'h01);
    exp_push(5,  3'd3, L_SG, 8'h02);
    exp_push(9,  3'd4, L_SY, 8'h02);
    exp_push(9,  3'd5, L_AR, 8'h01);
    exp_push(5,  3'd6, L_WK, 8'h02);
    exp_push(9,  3'd0, L_HG, 8'h03);
    pulse_inputs(5, 3, 1'b1, 1'b1);
    repeat (80) @(negedge clk);
    chk("both_queue", 16'(exp_q.size()), 16'd0);

    // Test 5: ped held high serves exactly one walk.
    do_reset();
    exp_push(13, 3'd1, L_HY, 8'h02);
    exp_push(9,  3'd2, L_AR, 8'h01);
    exp_push(5,  3'd6, L_WK, 8'h02);
    exp_push(9,  3'd0, L_HG, 8'h03);
    pulse_inputs(5, 50, 1'b0, 1'b1);
    repeat (60) @(negedge clk);
    chk("ped_hold_queue", 16'(exp_q.size()), 16'd0);
`else
    // Test 4: ped button has no effect without the walk phase.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      repeat (3) @(negedge clk);
      ped_btn = ~ped_btn;
      chk("ped_ign_phase", {13'h0, phase}, 16'h0);
      chk("ped_ign_walk", {15'h0, walk}, 16'h0);
    end
    ped_btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("ped_ign_queue", 16'(exp_q.size()), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
